// File: rtl/ifu.sv
// ifu - instruction fetch unit for the ECU.
//
// Steers the program counter with its strobes, reads one instruction byte per
// cycle from the data bus and assembles an opcode plus 0-3 operand bytes into
// a single instruction word for the execute stage. Execute can redirect the
// fetch stream at any time with a jump request.
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   di         data bus byte at the current program counter address
//   oe, ini    program counter output enable and advance strobe
//   lrc, ai    program counter load strobe and load value
//   jmp, jta   jump request and jump target from execute
//   op, opr    latched opcode and little-endian operand bytes
//   len        operand count taken from opcode bits [7:6]
//   iv, ack    instruction valid / consumed handshake with execute
module ifu #(
  parameter logic [15:0] RV = 16'h8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  di,
  output logic        oe,
  output logic        ini,
  output logic        lrc,
  output logic [15:0] ai,
  input  logic        jmp,
  input  logic [15:0] jta,
  output logic [7:0]  op,
  output logic [23:0] opr,
  output logic [1:0]  len,
  output logic        iv,
  input  logic        ack
);

  typedef enum logic [1:0] {FOP, FOPR, HOLD} state_t;

  state_t     state;
  logic [1:0] idx;
  logic       fetching;

  // Strobes are decoded from state; reset and jump both suppress fetching so
  // that lrc and ini can never be high together.
  always_comb begin
    fetching = (state == FOP) || (state == FOPR);
    oe       = !rst && !jmp && fetching;
    ini      = !rst && !jmp && fetching;
    lrc      = !rst && jmp;
    ai       = lrc ? jta : 16'h0000;
    iv       = !rst && (state == HOLD);
  end

  // Fetch sequencer. A jump discards any partial instruction and restarts at
  // the opcode fetch; the program counter is reloaded in the same cycle, so
  // no byte is taken from di while jumping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FOP;
      idx   <= 2'd0;
      op    <= 8'h00;
      opr   <= 24'h000000;
      len   <= 2'd0;
    end else if (jmp) begin
      state <= FOP;
    end else begin
      case (state)
        FOP: begin
          op    <= di;
          len   <= di[7:6];
          opr   <= 24'h000000;
          idx   <= 2'd0;
          state <= (di[7:6] == 2'd0) ? HOLD : FOPR;
        end
        FOPR: begin
          case (idx)
            2'd0:    opr[7:0]   <= di;
            2'd1:    opr[15:8]  <= di;
            default: opr[23:16] <= di;
          endcase
          idx <= idx + 2'd1;
          // len is at least 1 here, so len-1 is the last operand index
          if (idx == len - 2'd1) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (ack) begin
            state <= FOP;
          end
        end
        default: state <= FOP;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// tb_ifu - randomized self-checking bench for ifu.
//
// A byte-addressed memory and a program counter model form the environment.
// The reference model tracks the instruction as a count of bytes captured
// versus bytes needed and assembles op/opr/len arithmetically from the bytes
// seen on the bus.
module tb_ifu;

  localparam logic [15:0] RV = 16'h8000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  di;
  logic        oe;
  logic        ini;
  logic        lrc;
  logic [15:0] ai;
  logic        jmp;
  logic [15:0] jta;
  logic [7:0]  op;
  logic [23:0] opr;
  logic [1:0]  len;
  logic        iv;
  logic        ack;

  logic [7:0]  mem [0:65535];
  logic [15:0] pc;

  int tests = 0;
  int fails = 0;

  // reference model state
  int          mhave;
  int          mneed;
  logic [7:0]  mop;
  logic [23:0] mopr;
  logic [1:0]  mlen;

  ifu #(.RV(RV)) dut (
    .clk(clk), .rst(rst), .di(di), .oe(oe), .ini(ini), .lrc(lrc), .ai(ai),
    .jmp(jmp), .jta(jta), .op(op), .opr(opr), .len(len), .iv(iv), .ack(ack)
  );

  always #5 clk = ~clk;

  // program counter and combinational memory seen by the ifu
  assign di = mem[pc];

  always @(posedge clk) begin
    if (rst) pc <= RV;
    else if (lrc) pc <= ai;
    else if (ini) pc <= pc + 16'd1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, compare every output against the model, then
  // advance the model by what should happen at the coming edge.
  task automatic applyStimulus(input logic r, input logic j, input logic [15:0] t, input logic a);
    logic        fetch;
    logic        hold;
    logic [7:0]  b;
    @(negedge clk);
    rst = r;
    jmp = j;
    jta = t;
    ack = a;
    #1;
    fetch = (mhave == 0) || (mhave < mneed);
    hold  = !fetch;
    b     = di;
    checkOutput("oe",  {31'd0, oe},  {31'd0, !r && !j && fetch});
    checkOutput("ini", {31'd0, ini}, {31'd0, !r && !j && fetch});
    checkOutput("lrc", {31'd0, lrc}, {31'd0, !r && j});
    checkOutput("ai",  {16'd0, ai},  {16'd0, (!r && j) ? t : 16'h0000});
    checkOutput("iv",  {31'd0, iv},  {31'd0, !r && hold});
    checkOutput("op",  {24'd0, op},  {24'd0, mop});
    checkOutput("opr", {8'd0, opr},  {8'd0, mopr});
    checkOutput("len", {30'd0, len}, {30'd0, mlen});
    if (r) begin
      mhave = 0; mneed = 1; mop = 8'h00; mopr = 24'h0; mlen = 2'd0;
    end else if (j) begin
      mhave = 0;
    end else if (fetch) begin
      if (mhave == 0) begin
        mop   = b;
        mlen  = b[7:6];
        mopr  = 24'h0;
        mneed = int'(b[7:6]) + 1;
      end else begin
        mopr = mopr | (24'(b) << (8 * (mhave - 1)));
      end
      mhave++;
    end else if (a) begin
      mhave = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    // directed program at the reset vector
    mem[16'h8000] = 8'h05;
    mem[16'h8001] = 8'hC1; mem[16'h8002] = 8'h11;
    mem[16'h8003] = 8'h22; mem[16'h8004] = 8'h33;
    mem[16'h8005] = 8'h81; mem[16'h8006] = 8'hAA; mem[16'h8007] = 8'hBB;
    mem[16'h8008] = 8'h40; mem[16'h8009] = 8'h77;
    mem[16'h800A] = 8'hC2; mem[16'h800B] = 8'h01;
    mem[16'h800C] = 8'h02; mem[16'h800D] = 8'h03;

    rst = 1'b1; jmp = 1'b0; jta = 16'h0; ack = 1'b0;
    mhave = 0; mneed = 1; mop = 8'h00; mopr = 24'h0; mlen = 2'd0;
    repeat (2) @(posedge clk);

    // reset cycle with jmp/ack high must be ignored
    applyStimulus(1'b1, 1'b1, 16'h1234, 1'b1);

    // 0x05 with ack low: one fetch cycle, then held for several cycles
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
    // 0xC1 11 22 33, held then acked in first hold cycle
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
    // 0x81: jump during the second operand fetch
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h9000, 1'b0);
    // fetch at 0x9000 until held, then jmp and ack together
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h8008, 1'b1);
    // jmp held several cycles
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 16'h800A, 1'b0);
    // 0xC2 with reset during operand fetch
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(0, 149) == 0,
                    $urandom_range(0, 11) == 0,
                    16'($urandom),
                    $urandom_range(0, 2) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
